// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types and helpers for the pipeline hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

  localparam int c_reg_addr_w_dflt = 5;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MUL_BUSY = 1'b1
  } hz_state_e;

  // Width of the multiply down-counter; never narrower than one bit.
  function automatic int mul_cnt_width(input int lat);
    return (lat <= 2) ? 1 : $clog2(lat);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Width-parameterised up-counter that sticks at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Five-stage pipeline hazard controller (load-use, branch
//               flush, multi-cycle multiply freeze, stall-cycle counter).
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = c_reg_addr_w_dflt,
  parameter int MUL_LAT    = 4,
  parameter int PERF_W     = 32
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs2,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_branch_taken,
  input  logic                  ex_mul_start,
  output logic                  en_pc,
  output logic                  en_if_id,
  output logic                  en_id_ex,
  output logic                  en_ex_mem,
  output logic                  en_mem_wb,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic                  busy,
  output logic [PERF_W-1:0]     stall_cycles
);

  localparam int              c_cnt_w    = mul_cnt_width(MUL_LAT);
  localparam logic [c_cnt_w-1:0] c_mul_load = c_cnt_w'(MUL_LAT - 2);

  hz_state_e          r_state;
  hz_state_e          w_state_nxt;
  logic [c_cnt_w-1:0] r_mul_cnt;
  logic [c_cnt_w-1:0] w_mul_cnt_nxt;
  logic               w_load_use;

  // Register 0 is hard-wired zero, so a load targeting it never creates a hazard.
  assign w_load_use = ex_mem_read && (ex_rd != '0) &&
                      ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state   <= RUN;
      r_mul_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_mul_cnt <= w_mul_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_mul_cnt_nxt = r_mul_cnt;
    en_pc         = 1'b1;
    en_if_id      = 1'b1;
    en_id_ex      = 1'b1;
    en_ex_mem     = 1'b1;
    en_mem_wb     = 1'b1;
    flush_if_id   = 1'b0;
    flush_id_ex   = 1'b0;
    busy          = 1'b0;

    case (r_state)
      RUN: begin
        if (ex_branch_taken) begin
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end else if (ex_mul_start) begin
          en_pc         = 1'b0;
          en_if_id      = 1'b0;
          en_id_ex      = 1'b0;
          en_ex_mem     = 1'b0;
          w_mul_cnt_nxt = c_mul_load;
          w_state_nxt   = MUL_BUSY;
        end else if (w_load_use) begin
          en_pc       = 1'b0;
          en_if_id    = 1'b0;
          flush_id_ex = 1'b1;
        end
      end

      MUL_BUSY: begin
        busy = 1'b1;
        // Final cycle leaves all enables high so EX/MEM captures the product.
        if (r_mul_cnt != '0) begin
          en_pc         = 1'b0;
          en_if_id      = 1'b0;
          en_id_ex      = 1'b0;
          en_ex_mem     = 1'b0;
          w_mul_cnt_nxt = r_mul_cnt - c_cnt_w'(1);
        end else begin
          w_state_nxt = RUN;
        end
      end

      default: begin
        w_state_nxt   = RUN;
        w_mul_cnt_nxt = '0;
      end
    endcase
  end

  sat_counter #(
    .WIDTH (PERF_W)
  ) u_stall_cnt (
    .clk   (clk),
    .arst  (arst),
    .inc   (~en_pc),
    .count (stall_cycles)
  );

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Randomised and directed check of hazard_ctrl against a
//               cycle-phase reference model (two parameter sets).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_uses_rs2 = 1'b0, ex_mem_read = 1'b0;
  logic       ex_branch_taken = 1'b0, ex_mul_start = 1'b0;

  logic [7:0]  obs_a, obs_b;
  logic [31:0] stall_a;
  logic [3:0]  stall_b;

  int n_total = 0;
  int n_bad   = 0;

  // Model: phase 0 = not multiplying, phase p>0 = p cycles after multiply entry.
  int    m_phase [2];
  longint m_stall [2];
  int    m_lat   [2] = '{4, 2};
  int    m_pw    [2] = '{32, 4};

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_ADDR_W(5), .MUL_LAT(4), .PERF_W(32)) dut_a (
    .clk(clk), .arst(arst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs2(id_uses_rs2), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .ex_mul_start(ex_mul_start),
    .en_pc(obs_a[7]), .en_if_id(obs_a[6]), .en_id_ex(obs_a[5]),
    .en_ex_mem(obs_a[4]), .en_mem_wb(obs_a[3]), .flush_if_id(obs_a[2]),
    .flush_id_ex(obs_a[1]), .busy(obs_a[0]), .stall_cycles(stall_a)
  );

  hazard_ctrl #(.REG_ADDR_W(5), .MUL_LAT(2), .PERF_W(4)) dut_b (
    .clk(clk), .arst(arst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs2(id_uses_rs2), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .ex_mul_start(ex_mul_start),
    .en_pc(obs_b[7]), .en_if_id(obs_b[6]), .en_id_ex(obs_b[5]),
    .en_ex_mem(obs_b[4]), .en_mem_wb(obs_b[3]), .flush_if_id(obs_b[2]),
    .flush_id_ex(obs_b[1]), .busy(obs_b[0]), .stall_cycles(stall_b)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected {en_pc,en_if_id,en_id_ex,en_ex_mem,en_mem_wb,flush_if_id,flush_id_ex,busy}
  function automatic logic [7:0] model_out(input int k);
    logic lu;
    lu = ex_mem_read && (ex_rd != 0) &&
         ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
    if (m_phase[k] == 0) begin
      if (ex_branch_taken)   return 8'b11111_11_0;
      else if (ex_mul_start) return 8'b00001_00_0;
      else if (lu)           return 8'b00111_01_0;
      else                   return 8'b11111_00_0;
    end else if (m_phase[k] < m_lat[k] - 1) begin
      return 8'b00001_00_1;
    end else begin
      return 8'b11111_00_1;
    end
  endfunction

  task automatic step(input logic a, input logic br, input logic mul, input logic mr,
                      input logic u2, input logic [4:0] rd, input logic [4:0] r1,
                      input logic [4:0] r2);
    logic [7:0] exp [2];
    arst = a; ex_branch_taken = br; ex_mul_start = mul; ex_mem_read = mr;
    id_uses_rs2 = u2; ex_rd = rd; id_rs1 = r1; id_rs2 = r2;
    if (a) begin
      for (int k = 0; k < 2; k++) begin
        m_phase[k] = 0;
        m_stall[k] = 0;
      end
    end
    #1;
    for (int k = 0; k < 2; k++) exp[k] = model_out(k);
    check_val("ctl_a",   {56'd0, obs_a}, {56'd0, exp[0]});
    check_val("ctl_b",   {56'd0, obs_b}, {56'd0, exp[1]});
    check_val("stall_a", {32'd0, stall_a}, m_stall[0]);
    check_val("stall_b", {60'd0, stall_b}, m_stall[1]);
    if (!a) begin
      for (int k = 0; k < 2; k++) begin
        if (!exp[k][7] && m_stall[k] < ((longint'(1) << m_pw[k]) - 1))
          m_stall[k]++;
        if (m_phase[k] == 0)
          m_phase[k] = (!br && mul) ? 1 : 0;
        else
          m_phase[k] = (m_phase[k] == m_lat[k] - 1) ? 0 : m_phase[k] + 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = 0;
      m_stall[k] = 0;
    end
    @(posedge clk);
    #1;
    // Reset state, then load-use on rs1, on r0, and on an unused rs2.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 5, 5, 0);
    step(0, 0, 0, 0, 0, 5, 5, 0);
    check_val("lu_stall_cnt", {32'd0, stall_a}, 64'd1);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 5, 1, 5);
    step(0, 0, 0, 1, 1, 5, 1, 5);
    // Branch beats a matching load-use.
    step(0, 1, 0, 1, 0, 5, 5, 0);
    // Multiply held high four cycles, then low.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check_val("mul_stall_cnt", {32'd0, stall_a}, 64'd3);
    // Reset asserted in the second busy cycle, then a fresh multiply.
    step(0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, (i == 0), 0, 0, 0, 0, 0);
    // Saturation of the 4-bit counter.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 0, 7, 7, 0);
    check_val("sat_b", {60'd0, stall_b}, 64'd15);
    // Randomised traffic with small register range to provoke matches.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 5) == 0),
           $urandom_range(0, 1),
           $urandom_range(0, 1),
           5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)));
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
